// File: rtl/fractal_sync_pe_requester.sv
// fractal_sync_pe_requester
//   Per-PE front end for a 1D synchronization node RX port. Takes one barrier
//   request from the PE (valid/ready), emits a single-cycle request into the
//   tree, waits for the matching wake, and hands a completion status back to
//   the PE. A timer supervises the wait. A saturating counter records wakes
//   that did not match a pending barrier.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   sync_valid_i/sync_ready_o      PE barrier request handshake
//   sync_aggr_i, sync_id_i         requested aggregation mask / barrier id
//   done_valid_o/done_ready_i      completion handshake back to the PE
//   done_status_o                  00 OK, 01 RSP_ERR, 10 TIMEOUT, 11 BAD_REQ
//   req_sync_o, req_aggr_o, req_id_o   request pulse into the node
//   rsp_wake_i, rsp_error_i, rsp_aggr_i, rsp_id_i   wake response from node
//   busy_o                         barrier in flight (state != IDLE)
//   stray_cnt_o                    saturating count of unmatched wakes
module fractal_sync_pe_requester #(
  parameter int AGGREGATE_WIDTH = 1,
  parameter int ID_WIDTH        = 1,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int STRAY_CNT_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sync_valid_i,
  output logic                       sync_ready_o,
  input  logic [AGGREGATE_WIDTH-1:0] sync_aggr_i,
  input  logic [ID_WIDTH-1:0]        sync_id_i,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [1:0]                 done_status_o,
  output logic                       req_sync_o,
  output logic [AGGREGATE_WIDTH-1:0] req_aggr_o,
  output logic [ID_WIDTH-1:0]        req_id_o,
  input  logic                       rsp_wake_i,
  input  logic                       rsp_error_i,
  input  logic [AGGREGATE_WIDTH-1:0] rsp_aggr_i,
  input  logic [ID_WIDTH-1:0]        rsp_id_i,
  output logic                       busy_o,
  output logic [STRAY_CNT_WIDTH-1:0] stray_cnt_o
);

  // Timer must hold TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RSP_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD_REQ = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   status_q, status_d;
  logic [AGGREGATE_WIDTH-1:0]   aggr_q;
  logic [ID_WIDTH-1:0]          id_q;
  logic [TW-1:0]                timer_q;
  logic [STRAY_CNT_WIDTH-1:0]   stray_q;
  logic                         match;
  logic                         expire;

  // A wake only completes the barrier while actually waiting on it;
  // anything else is stray.
  assign match  = rsp_wake_i && (state_q == WAIT) &&
                  (rsp_id_i == id_q) && (rsp_aggr_i == aggr_q);
  assign expire = (TIMEOUT_CYCLES > 0) && (timer_q == TO_LAST);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      aggr_q   <= '0;
      id_q     <= '0;
      timer_q  <= '0;
      stray_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (state_q == IDLE && sync_valid_i) begin
        aggr_q <= sync_aggr_i;
        id_q   <= sync_id_i;
      end
      // Timer saturates rather than wrapping (matters when timeout disabled).
      if (state_q == ISSUE)
        timer_q <= '0;
      else if (state_q == WAIT && timer_q != '1)
        timer_q <= timer_q + TW'(1);
      if (rsp_wake_i && !match && stray_q != '1)
        stray_q <= stray_q + STRAY_CNT_WIDTH'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (sync_valid_i) begin
          if (sync_aggr_i == '0) begin
            state_d  = DONE;
            status_d = ST_BAD_REQ;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A match in the expiry cycle takes priority over the timeout.
        if (match) begin
          state_d  = DONE;
          status_d = rsp_error_i ? ST_RSP_ERR : ST_OK;
        end else if (expire) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end
      end
      DONE: if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    sync_ready_o  = (state_q == IDLE);
    req_sync_o    = (state_q == ISSUE);
    req_aggr_o    = (state_q == ISSUE) ? aggr_q : '0;
    req_id_o      = (state_q == ISSUE) ? id_q : '0;
    done_valid_o  = (state_q == DONE);
    done_status_o = (state_q == DONE) ? status_q : 2'b00;
    busy_o        = (state_q != IDLE);
  end

  assign stray_cnt_o = stray_q;

endmodule

// File: tb/tb_fractal_sync_pe_requester.sv
module tb_fractal_sync_pe_requester;
  localparam int AW   = 2;
  localparam int IW   = 1;
  localparam int TC   = 8;
  localparam int SW   = 4;
  localparam int MAXN = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sync_valid_i;
  logic          sync_ready_o;
  logic [AW-1:0] sync_aggr_i;
  logic [IW-1:0] sync_id_i;
  logic          done_valid_o;
  logic          done_ready_i;
  logic [1:0]    done_status_o;
  logic          req_sync_o;
  logic [AW-1:0] req_aggr_o;
  logic [IW-1:0] req_id_o;
  logic          rsp_wake_i;
  logic          rsp_error_i;
  logic [AW-1:0] rsp_aggr_i;
  logic [IW-1:0] rsp_id_i;
  logic          busy_o;
  logic [SW-1:0] stray_cnt_o;

  fractal_sync_pe_requester #(
    .AGGREGATE_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TC), .STRAY_CNT_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sync_valid_i(sync_valid_i), .sync_ready_o(sync_ready_o),
    .sync_aggr_i(sync_aggr_i), .sync_id_i(sync_id_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_status_o(done_status_o),
    .req_sync_o(req_sync_o), .req_aggr_o(req_aggr_o), .req_id_o(req_id_o),
    .rsp_wake_i(rsp_wake_i), .rsp_error_i(rsp_error_i),
    .rsp_aggr_i(rsp_aggr_i), .rsp_id_i(rsp_id_i),
    .busy_o(busy_o), .stray_cnt_o(stray_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int stray_tot = 0;  // unsaturated count of unmatched wakes since reset

  // Wake plan, indexed by cycle after request acceptance (0 = issue cycle).
  bit            w_v [MAXN];
  logic [AW-1:0] w_a [MAXN];
  logic [IW-1:0] w_i [MAXN];
  bit            w_e [MAXN];

  function automatic int sat(input int v);
    int lim;
    lim = (1 << SW) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_plan();
    for (int n = 0; n < MAXN; n++) begin
      w_v[n] = 1'b0; w_a[n] = '0; w_i[n] = '0; w_e[n] = 1'b0;
    end
  endtask

  task automatic add_wake(input int n, input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input bit e);
    w_v[n] = 1'b1; w_a[n] = a; w_i[n] = id; w_e[n] = e;
  endtask

  task automatic idle_inputs();
    sync_valid_i = 1'b0; sync_aggr_i = '0; sync_id_i = '0;
    done_ready_i = 1'b0;
    rsp_wake_i = 1'b0; rsp_error_i = 1'b0; rsp_aggr_i = '0; rsp_id_i = '0;
  endtask

  // One barrier from acceptance to completion handshake. Expected outcome is
  // derived from the wake plan: the first matching wake inside the wait
  // window decides the status, otherwise the window expires.
  task automatic run_barrier(input logic [AW-1:0] a, input logic [IW-1:0] id,
                             input int hold);
    int         done_n;
    int         match_n;
    logic [1:0] st;
    bit         req_cyc;
    chk("accept_ready", 32'(sync_ready_o), 32'd1);
    sync_valid_i = 1'b1; sync_aggr_i = a; sync_id_i = id;
    tick();
    match_n = -1;
    if (a == '0) begin
      done_n = 0;
      st     = 2'b11;
    end else begin
      done_n = 1 + TC;  // wait window is cycles 1..TC
      st     = 2'b10;
      for (int n = 1; n <= TC; n++)
        if (match_n < 0 && w_v[n] && w_a[n] == a && w_i[n] == id) begin
          match_n = n;
          done_n  = n + 1;
          st      = w_e[n] ? 2'b01 : 2'b00;
        end
    end
    for (int n = 0; n <= done_n + hold; n++) begin
      req_cyc = (n == 0) && (a != '0);
      chk("busy", 32'(busy_o), 32'd1);
      chk("ready_busy", 32'(sync_ready_o), 32'd0);
      chk("req_sync", 32'(req_sync_o), 32'(req_cyc));
      chk("req_aggr", 32'(req_aggr_o), req_cyc ? 32'(a) : 32'd0);
      chk("req_id", 32'(req_id_o), req_cyc ? 32'(id) : 32'd0);
      chk("done_valid", 32'(done_valid_o), 32'(n >= done_n));
      chk("done_status", 32'(done_status_o), (n >= done_n) ? 32'(st) : 32'd0);
      chk("stray", 32'(stray_cnt_o), 32'(sat(stray_tot)));
      // New requests while busy must be ignored.
      sync_valid_i = 1'($urandom_range(0, 1));
      sync_aggr_i  = AW'($urandom);
      sync_id_i    = IW'($urandom);
      rsp_wake_i   = w_v[n];
      rsp_aggr_i   = w_a[n];
      rsp_id_i     = w_i[n];
      rsp_error_i  = w_e[n];
      if (w_v[n] && n != match_n) stray_tot++;
      done_ready_i = (n == done_n + hold);
      tick();
    end
    idle_inputs();
    chk("post_done_valid", 32'(done_valid_o), 32'd0);
    chk("post_busy", 32'(busy_o), 32'd0);
    chk("post_ready", 32'(sync_ready_o), 32'd1);
    chk("post_stray", 32'(stray_cnt_o), 32'(sat(stray_tot)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [IW-1:0] rid;
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick();
    chk("rst_req_sync", 32'(req_sync_o), 32'd0);
    chk("rst_done_valid", 32'(done_valid_o), 32'd0);
    chk("rst_stray", 32'(stray_cnt_o), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("rst_ready", 32'(sync_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_status", 32'(done_status_o), 32'd0);
    chk("rst_req_aggr", 32'(req_aggr_o), 32'd0);

    // Normal barrier: wake three cycles into the wait.
    clear_plan(); add_wake(3, 2'b01, 1'b1, 1'b0);
    run_barrier(2'b01, 1'b1, 0);

    // Timeout with no wake, then a late wake while DONE is held.
    clear_plan(); add_wake(11, 2'b01, 1'b0, 1'b0);
    run_barrier(2'b01, 1'b0, 3);
    chk("timeout_stray", 32'(stray_cnt_o), 32'd1);

    // Mismatch filtering: wrong id, then wrong aggr, then the match.
    clear_plan();
    add_wake(2, 2'b10, 1'b1, 1'b0);
    add_wake(3, 2'b01, 1'b0, 1'b0);
    add_wake(5, 2'b10, 1'b0, 1'b0);
    run_barrier(2'b10, 1'b0, 0);
    chk("mismatch_stray", 32'(stray_cnt_o), 32'd3);

    // Match in the expiry cycle with error wins over timeout.
    clear_plan(); add_wake(TC, 2'b11, 1'b1, 1'b1);
    run_barrier(2'b11, 1'b1, 0);

    // BAD_REQ, with a wake landing in the DONE cycle.
    clear_plan(); add_wake(0, 2'b01, 1'b0, 1'b0);
    run_barrier(2'b00, 1'b1, 0);

    // Completion back-pressure held for five cycles.
    clear_plan(); add_wake(1, 2'b10, 1'b1, 1'b1);
    run_barrier(2'b10, 1'b1, 5);

    // Reset while waiting: barrier dropped, counters cleared.
    clear_plan();
    sync_valid_i = 1'b1; sync_aggr_i = 2'b11; sync_id_i = 1'b0;
    tick();
    sync_valid_i = 1'b0;
    tick();
    rsp_wake_i = 1'b1; rsp_aggr_i = 2'b01; rsp_id_i = 1'b1;
    tick();
    rsp_wake_i = 1'b0;
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_stray", 32'(stray_cnt_o), 32'd0);
    // A request presented alongside reset must not produce a pulse.
    sync_valid_i = 1'b1; sync_aggr_i = 2'b01;
    tick();
    rst_i = 1'b0; sync_valid_i = 1'b0;
    stray_tot = 0;
    chk("mid_no_req", 32'(req_sync_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("mid_no_done", 32'(done_valid_o), 32'd0);
      chk("mid_ready", 32'(sync_ready_o), 32'd1);
      tick();
    end

    // Randomized barriers and wake traffic; drives the stray counter into
    // saturation along the way.
    for (int b = 0; b < 60; b++) begin
      ra  = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(1, 3));
      rid = IW'($urandom);
      clear_plan();
      for (int n = 0; n < MAXN; n++)
        if ($urandom_range(0, 3) == 0)
          add_wake(n,
                   ($urandom_range(0, 1) == 1) ? ra : AW'($urandom),
                   ($urandom_range(0, 1) == 1) ? rid : IW'($urandom),
                   1'($urandom));
      run_barrier(ra, rid, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
